// File: rtl/fpu_divider.sv
// Iterative IEEE-754 single-precision divider (z = a / b). Radix-2 restoring
// division, one quotient bit per clock, round-to-nearest-even.
module fpu_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic [31:0] output_z,
    output logic        output_z_stb
);

    typedef enum logic [3:0] {
        S_GET_A, S_GET_B, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B, S_DIV_INIT,
        S_DIVIDE, S_DIV_DONE, S_NORM_2, S_ROUND, S_PACK, S_PUT_Z
    } state_t;

    localparam logic [31:0] QNAN = 32'hFFC0_0000;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
    logic [31:0]        out_z_q, out_z_d;
    logic               out_stb_q, out_stb_d;
    logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
    logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    logic [24:0]        rem_q, rem_d;
    logic [26:0]        quo_q, quo_d;
    logic [4:0]         count_q, count_d;
    logic               guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;

    logic a_inf, b_inf, a_nan, b_nan, a_zero, b_zero, q_bit;

    // Classification uses the raw unpacked exponent (field - 127).
    assign a_inf  = (a_e_q == 10'sd128);
    assign b_inf  = (b_e_q == 10'sd128);
    assign a_nan  = a_inf && (a_m_q != '0);
    assign b_nan  = b_inf && (b_m_q != '0);
    assign a_zero = (a_e_q == -10'sd127) && (a_m_q == '0);
    assign b_zero = (b_e_q == -10'sd127) && (b_m_q == '0);
    assign q_bit  = (rem_q >= {1'b0, b_m_q});

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        z_d       = z_q;
        out_z_d   = out_z_q;
        out_stb_d = 1'b0;
        a_m_d     = a_m_q;
        b_m_d     = b_m_q;
        z_m_d     = z_m_q;
        a_e_d     = a_e_q;
        b_e_d     = b_e_q;
        z_e_d     = z_e_q;
        a_s_d     = a_s_q;
        b_s_d     = b_s_q;
        z_s_d     = z_s_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        count_d   = count_q;
        guard_d   = guard_q;
        round_d   = round_q;
        sticky_d  = sticky_q;

        case (state_q)
            S_GET_A: if (input_a_stb) begin
                a_d     = input_a;
                state_d = S_GET_B;
            end
            S_GET_B: if (input_b_stb) begin
                b_d     = input_b;
                state_d = S_UNPACK;
            end
            S_UNPACK: begin
                a_m_d   = {1'b0, a_q[22:0]};
                b_m_d   = {1'b0, b_q[22:0]};
                a_e_d   = $signed({2'b00, a_q[30:23]}) - 10'sd127;
                b_e_d   = $signed({2'b00, b_q[30:23]}) - 10'sd127;
                a_s_d   = a_q[31];
                b_s_d   = b_q[31];
                state_d = S_SPECIAL;
            end
            S_SPECIAL: begin
                state_d = S_PUT_Z;
                if (a_nan || b_nan)        z_d = QNAN;
                else if (a_inf && b_inf)   z_d = QNAN;
                else if (a_inf)            z_d = {a_s_q ^ b_s_q, 8'hFF, 23'h0};
                else if (b_inf)            z_d = {a_s_q ^ b_s_q, 31'h0};
                else if (a_zero && b_zero) z_d = QNAN;
                else if (b_zero)           z_d = {a_s_q ^ b_s_q, 8'hFF, 23'h0};
                else if (a_zero)           z_d = {a_s_q ^ b_s_q, 31'h0};
                else begin
                    if (a_e_q == -10'sd127) a_e_d = -10'sd126;
                    else                    a_m_d[23] = 1'b1;
                    if (b_e_q == -10'sd127) b_e_d = -10'sd126;
                    else                    b_m_d[23] = 1'b1;
                    state_d = S_NORM_A;
                end
            end
            S_NORM_A: begin
                if (a_m_q[23]) state_d = S_NORM_B;
                else begin
                    a_m_d = a_m_q << 1;
                    a_e_d = a_e_q - 10'sd1;
                end
            end
            S_NORM_B: begin
                if (b_m_q[23]) state_d = S_DIV_INIT;
                else begin
                    b_m_d = b_m_q << 1;
                    b_e_d = b_e_q - 10'sd1;
                end
            end
            S_DIV_INIT: begin
                z_s_d   = a_s_q ^ b_s_q;
                z_e_d   = a_e_q - b_e_q;
                rem_d   = {1'b0, a_m_q};
                quo_d   = '0;
                count_d = '0;
                state_d = S_DIVIDE;
            end
            S_DIVIDE: begin
                rem_d   = (q_bit ? rem_q - {1'b0, b_m_q} : rem_q) << 1;
                quo_d   = {quo_q[25:0], q_bit};
                count_d = count_q + 5'd1;
                if (count_q == 5'd26) state_d = S_DIV_DONE;
            end
            S_DIV_DONE: begin
                // Mantissa ratio lies in (0.5, 2): the integer bit picks the alignment.
                if (quo_q[26]) begin
                    z_m_d    = quo_q[26:3];
                    guard_d  = quo_q[2];
                    round_d  = quo_q[1];
                    sticky_d = quo_q[0] | (rem_q != '0);
                end else begin
                    z_m_d    = quo_q[25:2];
                    guard_d  = quo_q[1];
                    round_d  = quo_q[0];
                    sticky_d = (rem_q != '0);
                    z_e_d    = z_e_q - 10'sd1;
                end
                state_d = S_NORM_2;
            end
            S_NORM_2: begin
                if (z_e_q < -10'sd126) begin
                    z_e_d    = z_e_q + 10'sd1;
                    z_m_d    = z_m_q >> 1;
                    guard_d  = z_m_q[0];
                    round_d  = guard_q;
                    sticky_d = sticky_q | round_q;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
                    z_m_d = z_m_q + 24'd1;
                    if (z_m_q == 24'hFF_FFFF) z_e_d = z_e_q + 10'sd1;
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                z_d = {z_s_q, z_e_q[7:0] + 8'd127, z_m_q[22:0]};
                if (z_e_q == -10'sd126 && !z_m_q[23]) z_d[30:23] = 8'h00;
                if (z_e_q > 10'sd127) z_d = {z_s_q, 8'hFF, 23'h0};
                state_d = S_PUT_Z;
            end
            S_PUT_Z: begin
                out_z_d   = z_q;
                out_stb_d = 1'b1;
                state_d   = S_GET_A;
            end
            default: state_d = S_GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_GET_A;
            out_z_q   <= '0;
            out_stb_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            out_z_q   <= out_z_d;
            out_stb_q <= out_stb_d;
            count_q   <= count_d;
        end
    end

    // NOTE: datapath registers carry no reset; each is written by the FSM
    // before it is read, so resetting them would only add fan-out on rst.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        z_q      <= z_d;
        a_m_q    <= a_m_d;
        b_m_q    <= b_m_d;
        z_m_q    <= z_m_d;
        a_e_q    <= a_e_d;
        b_e_q    <= b_e_d;
        z_e_q    <= z_e_d;
        a_s_q    <= a_s_d;
        b_s_q    <= b_s_d;
        z_s_q    <= z_s_d;
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        guard_q  <= guard_d;
        round_q  <= round_d;
        sticky_q <= sticky_d;
    end

    assign output_z     = out_z_q;
    assign output_z_stb = out_stb_q;

endmodule

// File: doc/fpu_divider.md
# fpu_divider

Iterative IEEE-754 single-precision divider, z = a / b, the inverse-operation companion to the PE floating-point multiplier inside the matrix multiplier. It uses the same per-operand strobe capture and one-cycle done-pulse protocol, so PE control can issue to either unit unchanged. The quotient is produced by a 27-step radix-2 restoring divider, one quotient bit per clock, then rounded round-to-nearest-even.

## Interface
- No parameters.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset: synchronous, active-high.
- input_a  input  32  dividend, IEEE-754 single.
- input_a_stb  input  1  qualifies input_a; sampled only in state get_a.
- input_b  input  32  divisor, IEEE-754 single.
- input_b_stb  input  1  qualifies input_b; sampled only in state get_b.
- output_z  output  32  quotient; registered, holds until the next result.
- output_z_stb  output  1  one-cycle pulse, high in the cycle output_z first shows a new result.

## Operation
- Reset: state=get_a, output_z=0, output_z_stb=0, iteration counter=0.
- get_a: capture a when input_a_stb=1, then go to get_b.
- get_b: capture b when input_b_stb=1, then go to unpack.
- Strobes are ignored in all other states. No queuing: a strobe seen while busy is lost.
- unpack:
  - Mantissa is 24 bits, frac with 0 in bit 23.
  - Exponent is 10-bit signed, exp-127.
  - Sign is kept per operand.
- special_cases, priority top-down; every match goes to put_z:
  - a or b NaN -> 0xFFC00000.
  - a inf and b inf -> 0xFFC00000.
  - a inf -> inf, sign a_s^b_s.
  - b inf -> signed zero.
  - a zero and b zero -> 0xFFC00000.
  - b zero -> signed inf.
  - a zero -> signed zero.
  - Otherwise: a denormal sets exp to -126, else set mantissa bit 23 (same rule for b), then go to normalise_a.
- normalise_a / normalise_b: shift mantissa left and decrement exp, one bit per cycle, until bit 23 is set. Each takes 1 cycle if already normal.
- div_init:
  - z_s=a_s^b_s; z_e=a_e-b_e.
  - rem (25-bit) = a_m; q (27-bit) = 0; count=0.
- divide, 27 cycles, one per count 0..26:
  - bit = (rem >= b_m).
  - rem = (bit ? rem-b_m : rem) << 1.
  - q = {q[25:0], bit}.
  - Leave for div_done after count 26.
- div_done:
  - q[26]=1: z_m=q[26:3], guard=q[2], round_bit=q[1], sticky=q[0] | (rem!=0).
  - q[26]=0: z_m=q[25:2], guard=q[1], round_bit=q[0], sticky=(rem!=0), and z_e-=1.
- normalise_2: while z_e < -126, do z_e+=1, z_m>>=1, guard<=z_m[0], round_bit<=guard, sticky|=round_bit.
- round:
  - If guard & (round_bit | sticky | z_m[0]), then z_m+=1.
  - If z_m was 0xFFFFFF before the increment, also z_e+=1.
- pack:
  - Fields are {z_s, z_e[7:0]+127, z_m[22:0]}.
  - Exponent field is 0 if z_e==-126 and z_m[23]==0 (denormal).
  - If z_e>127, result is {z_s, 0xFF, 0} (overflow to inf).
- put_z: output_z<=z, output_z_stb<=1, then return to get_a. output_z_stb is cleared on the next edge.

## Timing
- E0 = the edge that captures b.
- Special case: output_z_stb registered at E3, so it is high for the cycle after E3.
- Normal operands, no denormal shifting: stb registered at E37.
  - Breakdown: unpack 1, special 1, normalise 2, init 1, divide 27, div_done 1, normalise_2 1, round 1, pack 1, put_z 1.
- Add 1 cycle per normalise_a/normalise_b shift and per normalise_2 shift.
- a may be presented in the same cycle output_z_stb is high.
  - get_a is entered on the stb edge.
  - Next-operation b capture is at the earliest 1 cycle after a capture.
- input_a_stb and input_b_stb both high in get_a: only a is taken. b must be re-strobed in get_b.
- rst mid-operation: the next edge forces reset values, and the in-flight result is discarded (no stb).
- Back-to-back strobes while busy have no effect on the running operation.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> 0x40400000; stb exactly at E37, one cycle wide.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB; rounding up via sticky.
- Specials: 1/0 -> 0x7F800000; 0/0 -> 0xFFC00000; inf/inf -> 0xFFC00000; -2/inf -> 0x80000000; each at E3.
- 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 (overflow). 0x00800000 / 0x40000000 -> 0x00400000 (denormal result).
- rst asserted at divide count 10 -> no stb, output_z=0. A following 6/2 still returns 0x40400000 at E37.
- Random normal/denormal operand sweep vs. a real-valued reference model; bit-exact, with stb count equal to ops issued.
